// File: rtl/matrix_scan_bcm_if.sv
// Pixel request/ack bus between the scan engine (master) and framebuffer_fetch (slave).
interface matrix_scan_bcm_if #(
    parameter int COL_WIDTH   = 6,
    parameter int ROW_WIDTH   = 4,
    parameter int PLANE_WIDTH = 3
);
    logic                   pixel_req;
    logic                   pixel_ack;
    logic [COL_WIDTH-1:0]   column_address;
    logic [ROW_WIDTH-1:0]   row_address;
    logic [PLANE_WIDTH-1:0] bit_plane;
    logic [2:0]             rgb_top;
    logic [2:0]             rgb_bottom;

    modport master (
        output pixel_req, column_address, row_address, bit_plane,
        input  pixel_ack, rgb_top, rgb_bottom
    );

    modport slave (
        input  pixel_req, column_address, row_address, bit_plane,
        output pixel_ack, rgb_top, rgb_bottom
    );
endinterface

// File: rtl/matrix_scan_bcm.sv
// HUB75 scan engine with BCM plane timing; shifting of the next plane overlaps OE of the current one.
// Optional frame stall with frame_sync/frame_go when SCAN_FRAME_SYNC_EN is defined.
module matrix_scan_bcm #(
    parameter int COLUMNS       = 64,
    parameter int COL_WIDTH     = 6,
    parameter int ROW_PAIRS     = 16,
    parameter int ROW_WIDTH     = 4,
    parameter int BIT_DEPTH     = 6,
    parameter int PLANE_WIDTH   = 3,
    parameter int OE_BASE_TICKS = 16,
    parameter int OE_CNT_WIDTH  = 12,
    parameter int BLANK_TICKS   = 2
) (
    input  logic                 clk_in,
    input  logic                 reset,
`ifdef SCAN_FRAME_SYNC_EN
    output logic                 frame_sync,
    input  logic                 frame_go,
`endif
    matrix_scan_bcm_if.master    fetch,
    input  logic [BIT_DEPTH-1:0] plane_enable,
    output logic [2:0]           rgb1,
    output logic [2:0]           rgb2,
    output logic                 clk_pixel,
    output logic                 row_latch,
    output logic                 output_enable,
    output logic [ROW_WIDTH-1:0] row_address_active
);
    localparam logic [1:0] S_REQ = 2'd0, S_CLK_HI = 2'd1, S_CLK_LO = 2'd2, S_DONE = 2'd3;
    localparam logic [2:0] D_BLANK_PRE = 3'd0, D_ROWSET = 3'd1, D_BLANK_POST = 3'd2,
                           D_LATCH = 3'd3, D_SHOW = 3'd4;
    localparam int BLK_W = (BLANK_TICKS > 1) ? $clog2(BLANK_TICKS) : 1;

    logic [1:0]              shift_q, shift_d;
    logic [2:0]              disp_q, disp_d;
    logic [COL_WIDTH-1:0]    col_q, col_d;
    logic [ROW_WIDTH-1:0]    row_q, row_d, row_act_q, row_act_d;
    logic [PLANE_WIDTH-1:0]  plane_q, plane_d;
    logic [OE_CNT_WIDTH-1:0] timer_q, timer_d;
    logic [BLK_W-1:0]        blank_q, blank_d;
    logic [2:0]              rgb1_q, rgb1_d, rgb2_q, rgb2_d;
    logic                    en_q, en_d, armed_q, stall_q, stall_d;
    logic                    req, ack, latching, last_plane, last_row;

    // armed_q keeps pixel_req low until the first edge after reset release
    assign req        = (shift_q == S_REQ) && armed_q && !stall_q;
    assign ack        = req && fetch.pixel_ack;
    assign latching   = (disp_q == D_LATCH);
    assign last_plane = (plane_q == PLANE_WIDTH'(BIT_DEPTH - 1));
    assign last_row   = (row_q == ROW_WIDTH'(ROW_PAIRS - 1));

    always_comb begin
        shift_d = shift_q;
        col_d   = col_q;
        row_d   = row_q;
        plane_d = plane_q;
        rgb1_d  = rgb1_q;
        rgb2_d  = rgb2_q;
        case (shift_q)
            S_REQ: begin
                if (ack) begin
                    rgb1_d  = fetch.rgb_top;
                    rgb2_d  = fetch.rgb_bottom;
                    shift_d = S_CLK_HI;
                end
            end
            S_CLK_HI: shift_d = S_CLK_LO;
            S_CLK_LO: begin
                if (col_q == COL_WIDTH'(COLUMNS - 1)) begin
                    shift_d = S_DONE;
                end else begin
                    col_d   = col_q + 1'b1;
                    shift_d = S_REQ;
                end
            end
            default: begin
                // row/plane just latched is on display; start shifting its successor
                if (latching) begin
                    shift_d = S_REQ;
                    col_d   = '0;
                    if (last_plane) begin
                        plane_d = '0;
                        row_d   = last_row ? '0 : row_q + 1'b1;
                    end else begin
                        plane_d = plane_q + 1'b1;
                    end
                end
            end
        endcase
`ifdef SCAN_FRAME_SYNC_EN
        stall_d = stall_q;
        if (latching && last_plane && last_row)
            stall_d = 1'b1;
        else if (stall_q && frame_go)
            stall_d = 1'b0;
`else
        stall_d = 1'b0;
`endif
    end

    always_comb begin
        disp_d    = disp_q;
        blank_d   = blank_q;
        timer_d   = timer_q;
        en_d      = en_q;
        row_act_d = row_act_q;
        case (disp_q)
            D_BLANK_PRE: begin
                if (blank_q == BLK_W'(BLANK_TICKS - 1)) begin
                    blank_d = '0;
                    disp_d  = D_ROWSET;
                end else begin
                    blank_d = blank_q + 1'b1;
                end
            end
            D_ROWSET: begin
                row_act_d = row_q;
                disp_d    = D_BLANK_POST;
            end
            D_BLANK_POST: begin
                if (blank_q == BLK_W'(BLANK_TICKS - 1)) begin
                    blank_d = '0;
                    disp_d  = D_LATCH;
                end else begin
                    blank_d = blank_q + 1'b1;
                end
            end
            D_LATCH: begin
                timer_d = OE_CNT_WIDTH'(OE_BASE_TICKS) << plane_q;
                en_d    = plane_enable[plane_q];
                disp_d  = D_SHOW;
            end
            default: begin
                // OE stays low after expiry until the next plane is fully shifted
                if (timer_q != '0)
                    timer_d = timer_q - 1'b1;
                else if (shift_q == S_DONE)
                    disp_d = D_BLANK_PRE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            shift_q   <= S_REQ;
            disp_q    <= D_SHOW;
            col_q     <= '0;
            row_q     <= '0;
            plane_q   <= '0;
            row_act_q <= '0;
            timer_q   <= '0;
            blank_q   <= '0;
            rgb1_q    <= '0;
            rgb2_q    <= '0;
            en_q      <= 1'b0;
            armed_q   <= 1'b0;
            stall_q   <= 1'b0;
        end else begin
            shift_q   <= shift_d;
            disp_q    <= disp_d;
            col_q     <= col_d;
            row_q     <= row_d;
            plane_q   <= plane_d;
            row_act_q <= row_act_d;
            timer_q   <= timer_d;
            blank_q   <= blank_d;
            rgb1_q    <= rgb1_d;
            rgb2_q    <= rgb2_d;
            en_q      <= en_d;
            armed_q   <= 1'b1;
            stall_q   <= stall_d;
        end
    end

    assign fetch.pixel_req      = req;
    assign fetch.column_address = col_q;
    assign fetch.row_address    = row_q;
    assign fetch.bit_plane      = plane_q;
    assign rgb1                 = rgb1_q;
    assign rgb2                 = rgb2_q;
    assign clk_pixel            = (shift_q == S_CLK_HI);
    assign row_latch            = latching;
    assign output_enable        = (disp_q == D_SHOW) && (timer_q != '0) && en_q;
    assign row_address_active   = row_act_q;
`ifdef SCAN_FRAME_SYNC_EN
    assign frame_sync           = latching && last_plane && last_row;
`endif
endmodule

// File: tb/tb_matrix_scan_bcm.sv
// Directed bench for matrix_scan_bcm on a 4-column, 2-row-pair, 2-plane geometry.
`timescale 1ns/1ps
module tb_matrix_scan_bcm;
    localparam int COLS = 4, CW = 2, RP = 2, RW = 1, BD = 2, PW = 1;
    localparam int OEB = 16, OEW = 12, BLK = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [BD-1:0] plane_enable;
    logic [2:0]    rgb1, rgb2;
    logic          clk_pixel, row_latch, output_enable;
    logic [RW-1:0] row_address_active;
`ifdef SCAN_FRAME_SYNC_EN
    logic          frame_sync;
    logic          frame_go;
`endif

    matrix_scan_bcm_if #(.COL_WIDTH(CW), .ROW_WIDTH(RW), .PLANE_WIDTH(PW)) fif ();

    matrix_scan_bcm #(
        .COLUMNS(COLS), .COL_WIDTH(CW), .ROW_PAIRS(RP), .ROW_WIDTH(RW),
        .BIT_DEPTH(BD), .PLANE_WIDTH(PW), .OE_BASE_TICKS(OEB),
        .OE_CNT_WIDTH(OEW), .BLANK_TICKS(BLK)
    ) dut (
        .clk_in(clk),
        .reset(reset),
`ifdef SCAN_FRAME_SYNC_EN
        .frame_sync(frame_sync),
        .frame_go(frame_go),
`endif
        .fetch(fif),
        .plane_enable(plane_enable),
        .rgb1(rgb1),
        .rgb2(rgb2),
        .clk_pixel(clk_pixel),
        .row_latch(row_latch),
        .output_enable(output_enable),
        .row_address_active(row_address_active)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // fetch model: ack held high, or ack after 20 cycles of req in slow mode
    bit slow = 1'b0;
    int req_cnt = 0;
    initial begin
        fif.pixel_ack  = 1'b0;
        fif.rgb_top    = 3'b101;
        fif.rgb_bottom = 3'b010;
        forever begin
            @(posedge clk);
            #2;
            if (!slow) begin
                fif.pixel_ack = 1'b1;
            end else begin
                req_cnt = (fif.pixel_req === 1'b1) ? req_cnt + 1 : 0;
                fif.pixel_ack = (req_cnt >= 20);
            end
        end
    end

    // panel-side monitor, sampled on the falling edge
    int cyc = 0, pix_cnt = 0, oe_run = 0;
    int lat_n = 0, oe_n = 0, rq_n = 0, rise_n = 0, acc_n = 0, fs_n = 0;
    int inv_err = 0, rgb_err = 0;
    logic [1:0] lat_rp [16];
    int lat_cyc [16];
    int lat_pix [16];
    int oe_len [16];
    logic rq_after [16];
    logic p_clk = 1'b0, p_lat = 1'b0, p_oe = 1'b0;
    logic [RW-1:0] p_ra = '0;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                pix_cnt = 0;
                oe_run  = 0;
            end else begin
                if (clk_pixel && !p_clk) begin
                    pix_cnt++;
                    rise_n++;
                    if (rgb1 !== 3'b101 || rgb2 !== 3'b010) rgb_err++;
                end
                if (fif.pixel_req && fif.pixel_ack) acc_n++;
                if (p_lat && rq_n < 16) begin
                    rq_after[rq_n] = fif.pixel_req;
                    rq_n++;
                end
                if (row_latch && lat_n < 16) begin
                    lat_rp[lat_n]  = {row_address_active, fif.bit_plane};
                    lat_cyc[lat_n] = cyc;
                    lat_pix[lat_n] = pix_cnt;
                    lat_n++;
                    pix_cnt = 0;
                end
                if (output_enable) begin
                    oe_run++;
                end else if (oe_run != 0) begin
                    if (oe_n < 16) oe_len[oe_n] = oe_run;
                    oe_n++;
                    oe_run = 0;
                end
                if (row_latch && output_enable) inv_err++;
                if (row_latch && clk_pixel) inv_err++;
                if (row_address_active != p_ra && (output_enable || p_oe)) inv_err++;
`ifdef SCAN_FRAME_SYNC_EN
                if (frame_sync) fs_n++;
`endif
            end
            p_clk = clk_pixel;
            p_lat = row_latch;
            p_oe  = output_enable;
            p_ra  = row_address_active;
        end
    end

    task automatic clr_mon();
        lat_n = 0; oe_n = 0; rq_n = 0; rise_n = 0; acc_n = 0; fs_n = 0;
    endtask

    task automatic wait_latches(input int n, input int budget);
        int k = 0;
        while (lat_n < n && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        check_val("latch_wait", 32'(lat_n >= n), 32'd1);
    endtask

    task automatic restart();
        reset = 1'b0;
        clr_mon();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        plane_enable = 2'b11;
`ifdef SCAN_FRAME_SYNC_EN
        frame_go = 1'b1;
`endif
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_req", 32'(fif.pixel_req), 32'd0);
        check_val("rst_clkpix", 32'(clk_pixel), 32'd0);
        check_val("rst_latch", 32'(row_latch), 32'd0);
        check_val("rst_oe", 32'(output_enable), 32'd0);
        check_val("rst_rgb1", 32'(rgb1), 32'd0);
        check_val("rst_row_act", 32'(row_address_active), 32'd0);
        check_val("rst_col", 32'(fif.column_address), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_val("first_req", 32'(fif.pixel_req), 32'd1);
        check_val("first_no_shift", 32'(clk_pixel), 32'd0);

        // free-run, both planes enabled
        wait_latches(5, 400);
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            check_val("fr_order", 32'(lat_rp[i]), 32'({1'((i / 2) % 2), 1'(i % 2)}));
            check_val("fr_pixels", 32'(lat_pix[i]), 32'd4);
        end
        for (int i = 1; i < 5; i++)
            check_val("fr_latch_gap", 32'(lat_cyc[i] - lat_cyc[i-1]), (i % 2) ? 32'd23 : 32'd39);
        for (int i = 0; i < 4; i++) begin
            check_val("fr_oe_len", 32'(oe_len[i]), (i % 2) ? 32'd32 : 32'd16);
            check_val("fr_req_on_show", 32'(rq_after[i]), 32'd1);
        end
        check_val("fr_rise_vs_ack", 32'(rise_n), 32'(acc_n));

        // plane 0 masked
        plane_enable = 2'b10;
        restart();
        wait_latches(3, 300);
        check_val("pm_oe_runs", 32'(oe_n), 32'd1);
        check_val("pm_oe_len", 32'(oe_len[0]), 32'd32);
        check_val("pm_slot_kept", 32'(lat_cyc[1] - lat_cyc[0]), 32'd23);
        check_val("pm_order", 32'(lat_rp[1]), 32'd1);

        // slow fetch: shift outlasts both OE slots
        plane_enable = 2'b11;
        slow = 1'b1;
        restart();
        wait_latches(3, 700);
        check_val("sf_oe0", 32'(oe_len[0]), 32'd16);
        check_val("sf_oe1", 32'(oe_len[1]), 32'd32);
        check_val("sf_gap0", 32'(lat_cyc[1] - lat_cyc[0]), 32'd95);
        check_val("sf_gap1", 32'(lat_cyc[2] - lat_cyc[1]), 32'd95);
        for (int i = 0; i < 3; i++) begin
            check_val("sf_pixels", 32'(lat_pix[i]), 32'd4);
            check_val("sf_order", 32'(lat_rp[i]), 32'({1'(i / 2), 1'(i % 2)}));
        end
        check_val("sf_rise_vs_ack", 32'(rise_n), 32'(acc_n));

        // reset while shifting column 2 of (row 1, plane 1)
        slow = 1'b0;
        restart();
        begin
            int k = 0;
            while (!(fif.column_address == 2'd2 && fif.row_address == 1'b1 &&
                     fif.bit_plane == 1'b1) && k < 300) begin
                @(posedge clk);
                #1;
                k++;
            end
            check_val("rs_reach_col2", 32'(k < 300), 32'd1);
        end
        check_val("rs_pre_row_act", 32'(row_address_active), 32'd1);
        check_val("rs_pre_oe", 32'(output_enable), 32'd1);
        reset = 1'b0;
        #1;
        check_val("rs_req", 32'(fif.pixel_req), 32'd0);
        check_val("rs_clkpix", 32'(clk_pixel), 32'd0);
        check_val("rs_latch", 32'(row_latch), 32'd0);
        check_val("rs_oe", 32'(output_enable), 32'd0);
        check_val("rs_rgb", 32'({rgb1, rgb2}), 32'd0);
        check_val("rs_row_act", 32'(row_address_active), 32'd0);
        check_val("rs_addr", 32'({fif.column_address, fif.row_address, fif.bit_plane}), 32'd0);
        clr_mon();
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_val("rs_restart_req", 32'(fif.pixel_req), 32'd1);
        check_val("rs_restart_addr", 32'({fif.column_address, fif.row_address, fif.bit_plane}), 32'd0);
        wait_latches(1, 100);
        check_val("rs_first_latch", 32'(lat_rp[0]), 32'd0);
        check_val("rs_first_pixels", 32'(lat_pix[0]), 32'd4);

`ifdef SCAN_FRAME_SYNC_EN
        // frame stall until frame_go
        frame_go = 1'b0;
        restart();
        wait_latches(4, 400);
        begin
            int r0, req_hi, oe_hi;
            r0 = rise_n;
            req_hi = 0;
            oe_hi = 0;
            for (int i = 0; i < 120; i++) begin
                @(posedge clk);
                #1;
                if (fif.pixel_req) req_hi++;
                if (i >= 60 && output_enable) oe_hi++;
            end
            check_val("fs_pulses", 32'(fs_n), 32'd1);
            check_val("fs_req_held", 32'(req_hi), 32'd0);
            check_val("fs_oe_held", 32'(oe_hi), 32'd0);
            check_val("fs_no_shift", 32'(rise_n), 32'(r0));
        end
        frame_go = 1'b1;
        @(posedge clk);
        #1;
        check_val("fs_go_req", 32'(fif.pixel_req), 32'd1);
        check_val("fs_go_addr", 32'({fif.column_address, fif.row_address, fif.bit_plane}), 32'd0);
`endif

        check_val("invariants", 32'(inv_err), 32'd0);
        check_val("rgb_at_edge", 32'(rgb_err), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/matrix_scan_bcm.md
Name: matrix_scan_bcm

Overview:
- Parametrised successor to the fixed 64x32, 6-bit HUB75 scan engine.
- Generalises the panel geometry and colour depth, and adds binary-coded-modulation (BCM) plane timing with a per-plane brightness mask.
- Shifting of plane N+1 overlaps the OE on-time of plane N, and row changes are blanking-guarded.
- Sits between framebuffer_fetch (pixel request/ack handshake) and the panel pins, in the clk_matrix domain.

Parameters:
- COLUMNS, 64, pixels shifted per row-pair per plane.
- COL_WIDTH, 6, width of column_address; 2**COL_WIDTH >= COLUMNS.
- ROW_PAIRS, 16, scanned row pairs (panel height / 2).
- ROW_WIDTH, 4, width of row addresses; 2**ROW_WIDTH >= ROW_PAIRS.
- BIT_DEPTH, 6, number of BCM planes.
- PLANE_WIDTH, 3, width of bit_plane.
- OE_BASE_TICKS, 16, OE on-time of plane 0 in clk_in cycles; plane b gets OE_BASE_TICKS<<b.
- OE_CNT_WIDTH, 12, OE timer width; must hold OE_BASE_TICKS<<(BIT_DEPTH-1).
- BLANK_TICKS, 2, OE-low cycles before and after the row-address change.

Ports:
- clk_in  in  1  matrix clock.
- reset  in  1  asynchronous, active-low (asserted at 0).
- pixel_req  out  1  request for pixel data at column_address/row_address/bit_plane.
- pixel_ack  in  1  fetch data valid on rgb_top/rgb_bottom; sampled only while pixel_req=1.
- column_address  out  COL_WIDTH  column being requested.
- row_address  out  ROW_WIDTH  row pair being shifted (fetch side).
- bit_plane  out  PLANE_WIDTH  plane being shifted.
- rgb_top  in  3  plane bit for the top half, valid with pixel_ack.
- rgb_bottom  in  3  plane bit for the bottom half, valid with pixel_ack.
- plane_enable  in  BIT_DEPTH  per-plane OE mask; bit b=0 keeps timing but holds OE low.
- rgb1  out  3  panel R1/G1/B1.
- rgb2  out  3  panel R2/G2/B2.
- clk_pixel  out  1  panel shift clock.
- row_latch  out  1  panel latch.
- output_enable  out  1  active-high OE; the top level inverts it.
- row_address_active  out  ROW_WIDTH  panel A..D address, i.e. the row being displayed.

Behaviour:
- Reset values: all outputs 0; shift FSM in REQ at column 0, row 0, plane 0; OE timer expired; no plane loaded.
- Shift FSM, per pixel:
  - REQ: pixel_req=1; stays here until pixel_ack=1.
  - On ack: latch rgb_top/rgb_bottom into rgb1/rgb2 and go to CLK_HI.
  - CLK_HI: clk_pixel=1 for 1 cycle, then CLK_LO.
  - CLK_LO: clk_pixel=0 for 1 cycle. If column < COLUMNS-1: increment column, go to REQ. Otherwise go to DONE.
  - Minimum rate is 3 cycles/pixel, with ack high continuously.
  - pixel_ack while pixel_req=0 is ignored.
- DONE: waits until the OE timer has expired, then runs the display sequence.
- Display sequence (separate FSM):
  - BLANK_PRE: OE=0 for BLANK_TICKS cycles.
  - ROWSET: row_address_active <= row being committed; 1 cycle.
  - BLANK_POST: OE=0 for BLANK_TICKS cycles.
  - LATCH: row_latch=1 for exactly 1 cycle, clk_pixel=0.
  - SHOW: load OE timer with OE_BASE_TICKS<<plane. OE = plane_enable[plane] for exactly that many cycles.
- Overlap: on entry to SHOW, the shift FSM immediately starts the next (row, plane) at column 0, so shifting overlaps SHOW.
- If the shift time exceeds the SHOW time, OE falls at timer expiry and stays low until the shift completes. No latch may occur early.
- Sequence order:
  - plane increments 0..BIT_DEPTH-1.
  - At the last plane, plane wraps to 0 and row increments.
  - At row ROW_PAIRS-1 with the last plane, row and plane both wrap to 0 (frame wrap).
- plane_enable is sampled at LATCH; changes mid-SHOW take effect at the next plane.
- Invariants, each must hold every cycle:
  - row_latch and output_enable never both 1.
  - row_address_active never changes while OE=1.
  - clk_pixel=0 whenever row_latch=1.
- Reset asserted mid-operation: all outputs go to their reset values asynchronously.
- Reset release: the first pixel_req is asserted on the first clk_in edge after deassertion.

Optional Feature:
- Macro: SCAN_FRAME_SYNC_EN.
- Enabled:
  - Adds output frame_sync (1) and input frame_go (1).
  - frame_sync pulses 1 cycle on the LATCH of row ROW_PAIRS-1, plane BIT_DEPTH-1.
  - The shift FSM then holds REQ deasserted at row 0, plane 0, column 0 until frame_go=1 is sampled. This lets a buffer swap happen between frames.
  - The current SHOW completes normally; OE stays 0 after it until the stall ends.
- Disabled: the ports are absent and the engine free-runs across the frame wrap.

Test Plan:
- Bench parameters for all scenarios: COLUMNS=4, ROW_PAIRS=2, BIT_DEPTH=2, OE_BASE_TICKS=16, BLANK_TICKS=2.
- Free-run: pixel_ack tied 1, rgb_top=3'b101 -> exactly 4 clk_pixel rising edges between latches, rgb1=3'b101 at each edge. Latch order (row, plane) = (0,0),(0,1),(1,0),(1,1),(0,0).
- BCM timing: plane_enable=2'b11 -> OE high 16 cycles after plane-0 latch and 32 cycles after plane-1 latch. Shifting overlaps: pixel_req is high within 1 cycle of SHOW entry.
- Plane mask: plane_enable=2'b10 -> OE stays 0 during plane-0 SHOW but the 16-cycle slot is kept. OE=1 for 32 cycles during plane 1.
- Slow fetch: ack 20 cycles after each req -> shift time exceeds 16, OE falls after 16 cycles and the next latch waits for shift done. Invariants hold throughout; no ack-less shift.
- Reset mid-shift: drive reset=0 while on column 2 -> all outputs are 0 in the same cycle. After release, shifting restarts at column 0, row 0, plane 0.
- With SCAN_FRAME_SYNC_EN and frame_go=0: frame_sync pulses once and pixel_req stays 0 for at least 100 cycles. Setting frame_go=1 -> pixel_req rises next cycle with column 0, row 0, plane 0.
